track_segment_arbiter: RTL and testbench

Arbitrates one shared track segment among four trains that each reach it through a switch route. It owns the route switches and the per-train drive commands. Trains are granted in round-robin order. Switches settle before a train may proceed, and a clearance holdoff follows each exit. If a granted train never clears the segment, an occupancy timeout latches a fault. The block sits between the raw track sensors and the switch/drive outputs, above per-train drive logic.

---
 rtl/track_segment_arbiter.sv | 152 +++++++++++++++
 tb/tb_track_segment_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_segment_arbiter.sv
// Round-robin owner of one shared track segment: lines the route switch for the
// granted train, waits for the switches to settle, and holds other trains until clearance.
module track_segment_arbiter #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int CLEAR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       Clock,
    input  logic       RESET,
    input  logic [3:0] APPROACH,
    input  logic [3:0] EXIT,
    input  logic       FAULT_CLR,
    output logic [1:0] SW,
    output logic [7:0] D,
    output logic       BUSY,
    output logic       FAULT,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ROUTE    = 3'd1,
        S_OCCUPIED = 3'd2,
        S_CLEAR    = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  CLEAR_LD  = 8'(CLEAR_CYCLES);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  rr, rr_n;
    logic [1:0]  g, g_n;
    logic [7:0]  settle_cnt, settle_n;
    logic [7:0]  clear_cnt, clear_n;
    logic [15:0] tmo_cnt, tmo_n;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [1:0]  scan_idx;
    logic [7:0]  d_n;

    assign dbg_state = state;

    // Scan from the farthest offset back to the pointer so the nearest requester wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr;
        scan_idx   = rr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr + 2'(k);
            if (APPROACH[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_n  = state;
        rr_n     = rr;
        g_n      = g;
        settle_n = settle_cnt;
        clear_n  = clear_cnt;
        tmo_n    = tmo_cnt;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    g_n      = pick_idx;
                    settle_n = SETTLE_LD;
                    state_n  = S_ROUTE;
                end
            end
            S_ROUTE: begin
                if (!APPROACH[g]) begin
                    state_n = S_IDLE;
                end else if (settle_cnt == 8'd1) begin
                    state_n = S_OCCUPIED;
                    tmo_n   = 16'd0;
                    rr_n    = g + 2'd1;
                end else begin
                    settle_n = settle_cnt - 8'd1;
                end
            end
            S_OCCUPIED: begin
                // An exit on the timeout cycle still counts as a clean exit.
                if (EXIT[g]) begin
                    state_n = S_CLEAR;
                    clear_n = CLEAR_LD;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = S_FAULT;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            S_CLEAR: begin
                if (clear_cnt == 8'd1) begin
                    state_n = S_IDLE;
                end else begin
                    clear_n = clear_cnt - 8'd1;
                end
            end
            S_FAULT: begin
                if (FAULT_CLR) begin
                    state_n = S_CLEAR;
                    clear_n = CLEAR_LD;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Drive commands follow the state being entered so GO appears on the settle-expiry edge.
    always_comb begin
        d_n = 8'h55;
        for (int i = 0; i < 4; i++) begin
            if ((APPROACH[i] && !(g_n == 2'(i) && state_n == S_OCCUPIED)) ||
                (g_n == 2'(i) && state_n == S_FAULT)) begin
                d_n[2*i +: 2] = 2'b00;
            end
        end
    end

    always_ff @(posedge Clock or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            rr         <= 2'd0;
            g          <= 2'd0;
            settle_cnt <= 8'd0;
            clear_cnt  <= 8'd0;
            tmo_cnt    <= 16'd0;
            SW         <= 2'b00;
            D          <= 8'h55;
            BUSY       <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            state      <= state_n;
            rr         <= rr_n;
            g          <= g_n;
            settle_cnt <= settle_n;
            clear_cnt  <= clear_n;
            tmo_cnt    <= tmo_n;
            if (state == S_IDLE && pick_valid) begin
                SW <= pick_idx;
            end
            D     <= d_n;
            BUSY  <= (state_n != S_IDLE);
            FAULT <= (state_n == S_FAULT);
        end
    end

endmodule

// File: tb/tb_track_segment_arbiter.sv
// Bench for track_segment_arbiter: a timestamp-based reference model feeds an expected
// queue each clock, a negedge monitor compares, and directed scenarios add targeted checks.
module tb_track_segment_arbiter;

    localparam int S = 4;
    localparam int C = 8;
    localparam int T = 1024;

    localparam int MD_IDLE  = 0;
    localparam int MD_ROUTE = 1;
    localparam int MD_OCC   = 2;
    localparam int MD_CLEAR = 3;
    localparam int MD_FAULT = 4;

    logic       Clock = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] APPROACH = 4'b0;
    logic [3:0] EXIT = 4'b0;
    logic       FAULT_CLR = 1'b0;
    logic [1:0] SW;
    logic [7:0] D;
    logic       BUSY;
    logic       FAULT;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    int m_mode = MD_IDLE;
    int m_g = 0;
    int m_rr = 0;
    int m_deadline = 0;
    int m_cyc = 0;
    logic [1:0] m_sw = 2'b00;

    track_segment_arbiter #(
        .SETTLE_CYCLES(S),
        .CLEAR_CYCLES(C),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .Clock(Clock),
        .RESET(RESET),
        .APPROACH(APPROACH),
        .EXIT(EXIT),
        .FAULT_CLR(FAULT_CLR),
        .SW(SW),
        .D(D),
        .BUSY(BUSY),
        .FAULT(FAULT),
        .dbg_state(dbg_state)
    );

    always #5 Clock = ~Clock;

    // ---------------- reference model: deadlines as absolute edge numbers ----------------
    task automatic model_step();
        logic [3:0] a;
        logic [3:0] e;
        logic       fc;
        logic [7:0] exp_d;
        a  = APPROACH;
        e  = EXIT;
        fc = FAULT_CLR;
        m_cyc++;
        if (!RESET) begin
            m_mode = MD_IDLE;
            m_g    = 0;
            m_rr   = 0;
            m_sw   = 2'b00;
            exp_q.push_back({2'b00, 8'h55, 1'b0, 1'b0});
            return;
        end
        case (m_mode)
            MD_IDLE: begin
                if (a != 4'b0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (a[(m_rr + k) % 4]) begin
                            m_g = (m_rr + k) % 4;
                            break;
                        end
                    end
                    m_sw       = 2'(m_g);
                    m_mode     = MD_ROUTE;
                    m_deadline = m_cyc + S;
                end
            end
            MD_ROUTE: begin
                if (!a[m_g]) begin
                    m_mode = MD_IDLE;
                end else if (m_cyc == m_deadline) begin
                    m_mode     = MD_OCC;
                    m_rr       = (m_g + 1) % 4;
                    m_deadline = m_cyc + T;
                end
            end
            MD_OCC: begin
                if (e[m_g]) begin
                    m_mode     = MD_CLEAR;
                    m_deadline = m_cyc + C;
                end else if (m_cyc == m_deadline) begin
                    m_mode = MD_FAULT;
                end
            end
            MD_CLEAR: begin
                if (m_cyc == m_deadline) m_mode = MD_IDLE;
            end
            default: begin
                if (fc) begin
                    m_mode     = MD_CLEAR;
                    m_deadline = m_cyc + C;
                end
            end
        endcase
        exp_d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if ((a[i] && !(i == m_g && m_mode == MD_OCC)) || (i == m_g && m_mode == MD_FAULT))
                exp_d[2*i +: 2] = 2'b00;
            else
                exp_d[2*i +: 2] = 2'b01;
        end
        exp_q.push_back({m_sw, exp_d, (m_mode != MD_IDLE), (m_mode == MD_FAULT)});
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [11:0] exp_v;
        logic [11:0] got_v;
        logic        prev_busy;
        logic [1:0]  prev_sw;
        prev_busy = 1'b0;
        prev_sw   = 2'b00;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {SW, D, BUSY, FAULT};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_errors++;
                    $display("FAIL outputs t=%0t got sw=%0d d=%h busy=%b fault=%b exp sw=%0d d=%h busy=%b fault=%b",
                             $time, got_v[11:10], got_v[9:2], got_v[1], got_v[0],
                             exp_v[11:10], exp_v[9:2], exp_v[1], exp_v[0]);
                end
            end
            if (prev_busy === 1'b1 && BUSY === 1'b1) begin
                n_checks++;
                if (SW !== prev_sw) begin
                    n_errors++;
                    $display("FAIL sw_hold t=%0t got sw=%0d exp sw=%0d", $time, SW, prev_sw);
                end
            end
            prev_busy = BUSY;
            prev_sw   = SW;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge Clock);
            if (BUSY === lvl) break;
        end
        n_checks++;
        if (k == budget) begin
            n_errors++;
            $display("FAIL %s got busy=%b exp busy=%b within %0d cycles", name, BUSY, lvl, budget);
        end
    endtask

    // Finish a granted train: wait past settle, release approach, pulse its exit.
    task automatic finish_train(input logic [1:0] idx, input logic [3:0] approach_after);
        tick(S + 1);
        APPROACH = approach_after;
        EXIT = 4'b0001 << idx;
        tick(1);
        EXIT = 4'b0;
        wait_busy(1'b0, C + 10, "release");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_order[5];
        logic [1:0] got_g;
        int k;
        exp_order = '{0, 1, 2, 3, 0};

        tick(3);
        check("rst_sw", SW, 0);
        check("rst_d", D, 8'h55);
        check("rst_busy", BUSY, 0);
        check("rst_fault", FAULT, 0);
        RESET = 1'b1;
        tick(2);

        // round robin with all four trains waiting
        APPROACH = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_busy(1'b1, 20, "rr_grant");
            got_g = SW;
            check("rr_order", got_g, exp_order[r]);
            finish_train(got_g, (r == 4) ? 4'b0000 : 4'b1111);
        end

        // single request
        tick(1);
        APPROACH = 4'b0100;
        wait_busy(1'b1, 20, "single_grant");
        check("single_sw", SW, 2);
        finish_train(2'd2, 4'b0000);

        // contention: train 1 holds, train 3 waits and its early exit is ignored
        tick(1);
        APPROACH = 4'b0010;
        wait_busy(1'b1, 20, "cont_grant1");
        check("cont_sw1", SW, 1);
        tick(S + 1);
        APPROACH = 4'b1010;
        tick(1);
        EXIT = 4'b1000;
        tick(1);
        EXIT = 4'b0;
        tick(3);
        @(negedge Clock);
        check("cont_d3_occ", D[7:6], 0);
        check("cont_busy_occ", BUSY, 1);
        tick(1);
        EXIT = 4'b0010;
        APPROACH = 4'b1000;
        tick(1);
        EXIT = 4'b0;
        wait_busy(1'b0, C + 10, "cont_clear");
        @(negedge Clock);
        check("cont_sw3", SW, 3);
        check("cont_busy3", BUSY, 1);
        finish_train(2'd3, 4'b0000);

        // abort in ROUTE cycle 2 keeps the pointer
        tick(1);
        APPROACH = 4'b0001;
        wait_busy(1'b1, 20, "abort_grant");
        tick(1);
        APPROACH = 4'b0000;
        tick(2);
        check("abort_idle", BUSY, 0);
        APPROACH = 4'b0011;
        wait_busy(1'b1, 20, "abort_regrant");
        check("abort_sw", SW, 0);
        finish_train(2'd0, 4'b0000);

        // occupancy timeout, exit ignored in fault, then clear
        tick(1);
        APPROACH = 4'b0100;
        wait_busy(1'b1, 20, "tmo_grant");
        check("tmo_sw", SW, 2);
        tick(S + 1);
        APPROACH = 4'b0000;
        for (k = 0; k < T + 20; k++) begin
            @(negedge Clock);
            if (FAULT === 1'b1) break;
        end
        check("fault_set", FAULT, 1);
        check("fault_d", D[5:4], 0);
        tick(1);
        EXIT = 4'b0100;
        tick(1);
        EXIT = 4'b0;
        tick(3);
        check("fault_hold", FAULT, 1);
        FAULT_CLR = 1'b1;
        tick(1);
        FAULT_CLR = 1'b0;
        check("fault_clr", FAULT, 0);
        check("fault_clr_busy", BUSY, 1);
        wait_busy(1'b0, C + 10, "fault_release");

        // stray FAULT_CLR in IDLE
        tick(1);
        FAULT_CLR = 1'b1;
        tick(1);
        FAULT_CLR = 1'b0;
        check("stray_clr_fault", FAULT, 0);
        check("stray_clr_busy", BUSY, 0);

        // exit on the exact timeout edge
        APPROACH = 4'b0001;
        wait_busy(1'b1, 20, "edge_grant");
        check("edge_sw", SW, 0);
        tick(S + 1);
        APPROACH = 4'b0000;
        tick(T - 2);
        EXIT = 4'b0001;
        tick(1);
        EXIT = 4'b0;
        check("edge_fault", FAULT, 0);
        check("edge_busy", BUSY, 1);
        wait_busy(1'b0, C + 10, "edge_release");

        // asynchronous reset in the middle of ROUTE
        tick(1);
        APPROACH = 4'b0100;
        wait_busy(1'b1, 20, "arst_grant");
        tick(1);
        #2;
        RESET = 1'b0;
        exp_q.delete();
        #1;
        check("arst_sw", SW, 0);
        check("arst_d", D, 8'h55);
        check("arst_busy", BUSY, 0);
        check("arst_fault", FAULT, 0);
        tick(2);
        RESET = 1'b1;
        APPROACH = 4'b1010;
        wait_busy(1'b1, 20, "arst_regrant");
        check("arst_sw1", SW, 1);
        finish_train(2'd1, 4'b0000);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) APPROACH = APPROACH ^ (4'b0001 << $urandom_range(0, 3));
            EXIT = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            FAULT_CLR = ($urandom_range(0, 31) == 0);
            tick(1);
        end
        APPROACH = 4'b0;
        EXIT = 4'b0;
        FAULT_CLR = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
